// File: rtl/risc_v_dmem_responder.sv
// Data-side responder for the single-cycle risc_v_32 core:
// word RAM plus LED, cycle counter, compare timer and switch MMIO.
module risc_v_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] D_OUT_ADDR,
  input  logic [31:0] D_OUT,
  input  logic [31:0] WR,
  input  logic [31:0] D_IN_ADDR,
  output logic [31:0] D_IN,
  input  logic [15:0] SW,
  output logic [31:0] LED,
  output logic        IRQ
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  localparam logic [2:0] OFF_LED   = 3'd0;
  localparam logic [2:0] OFF_CYC   = 3'd1;
  localparam logic [2:0] OFF_TCMP  = 3'd2;
  localparam logic [2:0] OFF_TSTAT = 3'd3;
  localparam logic [2:0] OFF_SW    = 3'd4;

  function automatic logic in_ram(input logic [31:0] a);
    return (a >> (AW + 2)) == 32'd0;
  endfunction

  function automatic logic in_mmio(input logic [31:0] a);
    return a[31:5] == MMIO_BASE[31:5];
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [31:0] m
  );
    return (old & ~m) | (wd & m);
  endfunction

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0] led_q,  led_d;
  logic [31:0] cyc_q,  cyc_d;
  logic [31:0] tcmp_q, tcmp_d;
  logic        ten_q,  ten_d;
  logic        pend_q, pend_d;
  logic [15:0] sw1_q,  sw2_q;

  logic          wr_any;
  logic          wr_ram;
  logic          wr_mmio;
  logic [2:0]    w_off;
  logic [AW-1:0] w_idx;
  logic          rd_ram;
  logic          rd_mmio;
  logic [2:0]    r_off;
  logic [AW-1:0] r_idx;
  logic          pend_set;
  logic          pend_clr;

  assign wr_any  = |WR;
  assign wr_ram  = wr_any & in_ram(D_OUT_ADDR);
  assign wr_mmio = wr_any & in_mmio(D_OUT_ADDR);
  assign w_off   = D_OUT_ADDR[4:2];
  assign w_idx   = D_OUT_ADDR[AW+1:2];

  assign rd_ram  = in_ram(D_IN_ADDR);
  assign rd_mmio = in_mmio(D_IN_ADDR);
  assign r_off   = D_IN_ADDR[4:2];
  assign r_idx   = D_IN_ADDR[AW+1:2];

  always_comb begin
    led_d    = led_q;
    tcmp_d   = tcmp_q;
    ten_d    = ten_q;
    pend_clr = 1'b0;
    if (wr_mmio) begin
      case (w_off)
        OFF_LED:   led_d  = merge(led_q, D_OUT, WR);
        OFF_TCMP:  tcmp_d = merge(tcmp_q, D_OUT, WR);
        OFF_TSTAT: begin
          ten_d    = (ten_q & ~WR[1]) | (D_OUT[1] & WR[1]);
          pend_clr = WR[0] & D_OUT[0];
        end
        default: ;
      endcase
    end
  end

  // compare sees the pre-increment count and the old TEN
  assign pend_set = ten_q && (cyc_q == tcmp_q);
  assign pend_d   = pend_set | (pend_q & ~pend_clr);
  assign cyc_d    = cyc_q + 32'd1;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      led_q  <= '0;
      cyc_q  <= '0;
      tcmp_q <= '0;
      ten_q  <= 1'b0;
      pend_q <= 1'b0;
      sw1_q  <= '0;
      sw2_q  <= '0;
    end else begin
      led_q  <= led_d;
      cyc_q  <= cyc_d;
      tcmp_q <= tcmp_d;
      ten_q  <= ten_d;
      pend_q <= pend_d;
      sw1_q  <= SW;
      sw2_q  <= sw1_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET_N && wr_ram) begin
      mem_q[w_idx] <= merge(mem_q[w_idx], D_OUT, WR);
    end
  end

  always_comb begin
    D_IN = '0;
    unique case (1'b1)
      rd_ram: D_IN = mem_q[r_idx];
      rd_mmio: begin
        case (r_off)
          OFF_LED:   D_IN = led_q;
          OFF_CYC:   D_IN = cyc_q;
          OFF_TCMP:  D_IN = tcmp_q;
          OFF_TSTAT: D_IN = {30'b0, ten_q, pend_q};
          OFF_SW:    D_IN = {16'b0, sw2_q};
          default:   D_IN = '0;
        endcase
      end
      default: D_IN = '0;
    endcase
  end

  assign LED = led_q;
  assign IRQ = pend_q;

endmodule

// File: tb/tb_risc_v_dmem_responder.sv
// Bench for risc_v_dmem_responder: directed vectors checked against
// a behavioural memory/peripheral model plus literal expectations.
module tb_risc_v_dmem_responder;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] MB    = 32'hFFFF_0000;
  localparam logic [31:0] ONES  = 32'hFFFF_FFFF;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [31:0] D_OUT_ADDR = '0;
  logic [31:0] D_OUT = '0;
  logic [31:0] WR = '0;
  logic [31:0] D_IN_ADDR = '0;
  logic [31:0] D_IN;
  logic [15:0] SW = '0;
  logic [31:0] LED;
  logic        IRQ;

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 0;

  risc_v_dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .MMIO_BASE(MB)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .D_OUT_ADDR(D_OUT_ADDR),
    .D_OUT(D_OUT),
    .WR(WR),
    .D_IN_ADDR(D_IN_ADDR),
    .D_IN(D_IN),
    .SW(SW),
    .LED(LED),
    .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  // behavioural model
  logic [31:0] m_ram [int];
  logic [31:0] m_led, m_cyc, m_tcmp;
  bit          m_ten, m_pend;
  logic [15:0] m_sw [2];

  function automatic logic [31:0] model_read(input logic [31:0] a,
                                             output bit ok);
    longint unsigned ua;
    ua = a;
    ok = 1;
    if (ua < DEPTH * 4) begin
      if (m_ram.exists(int'(ua / 4))) return m_ram[int'(ua / 4)];
      ok = 0;
      return '0;
    end
    if (ua >= MB && ua < longint'(MB) + 32) begin
      case ((ua - MB) / 4)
        0: return m_led;
        1: return m_cyc;
        2: return m_tcmp;
        3: return {30'b0, m_ten, m_pend};
        4: return {16'b0, m_sw[1]};
        default: return '0;
      endcase
    end
    return '0;
  endfunction

  always @(posedge CLK) begin
    longint unsigned ua;
    bit match, clr;
    int idx;
    if (!RESET_N) begin
      m_led = 0; m_cyc = 0; m_tcmp = 0;
      m_ten = 0; m_pend = 0;
      m_sw[0] = 0; m_sw[1] = 0;
    end else begin
      ua = D_OUT_ADDR;
      match = m_ten && (m_cyc == m_tcmp);
      clr = 0;
      if (WR != 0) begin
        if (ua < DEPTH * 4) begin
          idx = int'(ua / 4);
          if (m_ram.exists(idx))
            m_ram[idx] = (m_ram[idx] & ~WR) | (D_OUT & WR);
          else if (WR == ONES)
            m_ram[idx] = D_OUT;
        end else if (ua >= MB && ua < longint'(MB) + 32) begin
          case ((ua - MB) / 4)
            0: m_led = (m_led & ~WR) | (D_OUT & WR);
            2: m_tcmp = (m_tcmp & ~WR) | (D_OUT & WR);
            3: begin
              if (WR[1]) m_ten = D_OUT[1];
              clr = WR[0] && D_OUT[0];
            end
            default: ;
          endcase
        end
      end
      m_pend = match || (m_pend && !clr);
      m_cyc = m_cyc + 1;
      m_sw[1] = m_sw[0];
      m_sw[0] = SW;
    end
  end

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    logic [31:0] e;
    bit ok;
    if (chk_en) begin
      e = model_read(D_IN_ADDR, ok);
      if (ok) chk("din_model", D_IN, e);
      chk("led_model", LED, m_led);
      chk("irq_model", {31'b0, IRQ}, {31'b0, m_pend});
    end
  end

  task automatic step(input logic [31:0] wa, input logic [31:0] wd,
                      input logic [31:0] wm, input logic [31:0] ra);
    @(posedge CLK);
    #1;
    D_OUT_ADDR = wa;
    D_OUT = wd;
    WR = wm;
    D_IN_ADDR = ra;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge CLK);
    // counter after reset release
    step(0, 0, 0, MB + 4); RESET_N = 1; chk_en = 1;
    @(negedge CLK); chk("cyc0", D_IN, 0);
    chk("led_rst", LED, 0); chk("irq_rst", {31'b0, IRQ}, 0);
    step(0, 0, 0, MB + 4); @(negedge CLK); chk("cyc1", D_IN, 1);
    step(0, 0, 0, MB + 4); @(negedge CLK); chk("cyc2", D_IN, 2);
    // RAM mask write
    step(32'h10, 32'hDEADBEEF, ONES, MB + 4);
    step(32'h10, 32'h0000_1234, 32'h0000_FFFF, 32'h10);
    @(negedge CLK); chk("ram_pre", D_IN, 32'hDEADBEEF);
    step(0, 0, 0, 32'h10); @(negedge CLK); chk("ram_mask", D_IN, 32'hDEAD1234);
    step(0, 0, 0, 32'h12); @(negedge CLK); chk("ram_lowbits", D_IN, 32'hDEAD1234);
    // same-cycle read/write
    step(32'h20, 5, ONES, 0);
    step(32'h20, 7, ONES, 32'h20); @(negedge CLK); chk("rw_old", D_IN, 5);
    step(0, 0, 0, 32'h20); @(negedge CLK); chk("rw_new", D_IN, 7);
    // out-of-range RAM write and read
    step(0, 32'h1111_1111, ONES, 0);
    step(DEPTH * 4, 32'h99, ONES, 0);
    step(0, 0, 0, DEPTH * 4); @(negedge CLK); chk("oob_read", D_IN, 0);
    step(0, 0, 0, 0); @(negedge CLK); chk("oob_nowrap", D_IN, 32'h1111_1111);
    step(MB + 32'h14, 32'h55, ONES, MB + 32'h14);
    step(MB + 4, 32'h1000, ONES, MB + 32'h14);
    @(negedge CLK); chk("unmapped", D_IN, 0);
    // switch synchronizer
    step(0, 0, 0, MB + 32'h10); SW = 16'hA5A5;
    @(negedge CLK); chk("sw_c0", D_IN, 0);
    step(0, 0, 0, MB + 32'h10); @(negedge CLK); chk("sw_c1", D_IN, 0);
    step(0, 0, 0, MB + 32'h10); @(negedge CLK); chk("sw_c2", D_IN, 32'hA5A5);
    // LED write and masked update
    step(MB, 32'hF0, ONES, MB); @(negedge CLK); chk("led_pre", LED, 0);
    step(MB, 32'h0F0F, 32'hFF, MB); @(negedge CLK); chk("led_f0", LED, 32'hF0);
    step(0, 0, 0, MB); @(negedge CLK); chk("led_mask", D_IN, 32'h0F);
    // reset with a dropped RAM write
    step(32'h10, 0, ONES, 0); RESET_N = 0;
    // timer, cycle numbers after release shown as tN
    step(MB + 8, 20, ONES, MB + 4); RESET_N = 1;
    @(negedge CLK); chk("cyc_restart", D_IN, 0); chk("led_cleared", LED, 0);
    step(MB + 32'hC, 2, ONES, 32'h10);
    @(negedge CLK); chk("ram_keep", D_IN, 32'hDEAD1234);
    repeat (18) step(0, 0, 0, MB + 32'hC);
    step(0, 0, 0, MB + 4);
    @(negedge CLK); chk("t20_cyc", D_IN, 20); chk("t20_irq", {31'b0, IRQ}, 0);
    step(0, 0, 0, MB + 32'hC);
    @(negedge CLK); chk("t21_irq", {31'b0, IRQ}, 1); chk("t21_stat", D_IN, 3);
    step(MB + 32'hC, 3, 3, MB + 32'hC);
    @(negedge CLK); chk("t22_stat", D_IN, 3);
    step(MB + 8, 30, ONES, MB + 32'hC);
    @(negedge CLK); chk("t23_irq", {31'b0, IRQ}, 0); chk("t23_stat", D_IN, 2);
    repeat (6) step(0, 0, 0, MB + 4);
    step(MB + 32'hC, 1, 1, MB + 4);
    @(negedge CLK); chk("t30_cyc", D_IN, 30);
    step(0, 0, 0, MB + 32'hC);
    @(negedge CLK); chk("setwins_irq", {31'b0, IRQ}, 1); chk("t31_stat", D_IN, 3);
    step(MB + 32'hC, 1, 3, MB + 32'hC);
    step(MB + 8, 40, ONES, MB + 32'hC);
    @(negedge CLK); chk("t33_stat", D_IN, 0); chk("t33_irq", {31'b0, IRQ}, 0);
    repeat (6) step(0, 0, 0, MB + 4);
    step(MB + 32'hC, 2, ONES, MB + 4);
    @(negedge CLK); chk("t40_cyc", D_IN, 40);
    step(MB + 8, 44, ONES, MB + 32'hC);
    @(negedge CLK); chk("oldten_irq", {31'b0, IRQ}, 0); chk("t41_stat", D_IN, 2);
    step(MB, 32'hF0, ONES, MB + 4);
    step(0, 0, 0, MB + 4);
    step(0, 0, 0, MB + 4); @(negedge CLK); chk("t44_cyc", D_IN, 44);
    // reset while IRQ and LED are set
    step(32'h10, 0, ONES, MB); RESET_N = 0;
    @(negedge CLK); chk("pre_rst_irq", {31'b0, IRQ}, 1);
    chk("pre_rst_led", LED, 32'hF0);
    step(0, 0, 0, MB + 4); RESET_N = 1;
    @(negedge CLK); chk("rst_led", LED, 0); chk("rst_irq", {31'b0, IRQ}, 0);
    chk("rst_cyc", D_IN, 0);
    step(0, 0, 0, 32'h10); @(negedge CLK); chk("rst_ram", D_IN, 32'hDEAD1234);
    // counter wrap
    step(0, 0, 0, MB + 4);
    force dut.cyc_q = 32'hFFFF_FFFD;
    m_cyc = 32'hFFFF_FFFD;
    #1;
    release dut.cyc_q;
    @(negedge CLK); chk("wrap_fd", D_IN, 32'hFFFF_FFFD);
    step(0, 0, 0, MB + 4); @(negedge CLK); chk("wrap_fe", D_IN, 32'hFFFF_FFFE);
    step(0, 0, 0, MB + 4); @(negedge CLK); chk("wrap_ff", D_IN, 32'hFFFF_FFFF);
    step(0, 0, 0, MB + 4); @(negedge CLK); chk("wrap_0", D_IN, 0);
    step(0, 0, 0, MB + 4); @(negedge CLK); chk("wrap_1", D_IN, 1);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/risc_v_dmem_responder.md
# risc_v_dmem_responder

Data-side responder for the single-cycle `risc_v_32` core. It receives the core's write address, write data and bit-mask write enable, and returns read data combinationally so the core's load completes in the same cycle. It contains a word RAM plus a small memory-mapped peripheral window: an LED register, a free-running cycle counter, a compare timer with a sticky pending flag and IRQ, and a synchronized switch input. It sits between the core's data port and the board I/O.

## Interface

Parameters:
- `DEPTH_WORDS`, 256: RAM size in 32-bit words; power of two.
- `MMIO_BASE`, 32'hFFFF_0000: base byte address of the peripheral window, which is 32 bytes long.

Ports:
- `CLK`  in  1: single clock; all state updates on the rising edge.
- `RESET_N`  in  1: reset, synchronous and active-low.
- `D_OUT_ADDR`  in  32: byte address for writes.
- `D_OUT`  in  32: write data.
- `WR`  in  32: per-bit write mask; bit i set writes bit i; all-zero means no write.
- `D_IN_ADDR`  in  32: byte address for reads.
- `D_IN`  out  32: read data, combinational from `D_IN_ADDR` and current state.
- `SW`  in  16: asynchronous board switches.
- `LED`  out  32: LED register contents.
- `IRQ`  out  1: timer pending flag.

## Operation

- Address decode uses the byte address with `addr[1:0]` ignored, so accesses are word-granular. Read and write decode independently.
- RAM region: byte addresses 0 to `DEPTH_WORDS*4-1`. The word index is `addr[log2(DEPTH_WORDS)+1:2]`.
- Write rule for every writable location: `new = (old & ~WR) | (D_OUT & WR)`.
- Writes to unmapped addresses are dropped. Reads from unmapped addresses return 0.
- MMIO map, as offsets from `MMIO_BASE`:
  - +0x00 `LED_REG` (rw): drives `LED`.
  - +0x04 `CYCLE` (ro): 32-bit free-running counter; +1 every cycle; wraps 0xFFFF_FFFF to 0; writes ignored.
  - +0x08 `TCMP` (rw): timer compare value.
  - +0x0C `TSTAT` (rw1c): bit0 is `PEND`; bit1 is `TEN` (rw). Writing 1 to bit0 with the `WR` bit set clears `PEND`. Bits [31:2] read 0.
  - +0x10 `SWREG` (ro): `{16'b0, sw_sync}`.
  - +0x14 to +0x1C: unmapped.
- Timer: `PEND` is set on the edge where `TEN`=1 and `CYCLE == TCMP`, comparing against the pre-increment value. `IRQ = PEND`.
- If a set and a clear of `PEND` occur on the same edge, the set wins and `PEND` = 1.
- `SW` passes through a 2-flop synchronizer to produce `sw_sync`.

## Timing

- Reads are combinational, with zero latency.
- Writes commit on the rising edge of `CLK`. When the read and write address match in the same cycle, `D_IN` returns the pre-write value; the new value is visible the following cycle.
- A `TEN` write and a compare on the same edge: the compare uses the old `TEN`.
- A `CYCLE` read returns the current value; the value increments at the edge.
- `SW` to `SWREG` latency is 2 cycles.
- Reset, on an edge with `RESET_N`=0:
  - `LED_REG`, `TCMP`, `TSTAT` are cleared to 0, `CYCLE` to 0, and the synchronizer flops to 0.
  - `LED`=0 and `IRQ`=0 from the next cycle on.
  - Any write presented during reset is dropped.
  - RAM contents are not reset.
- Reset asserted mid-operation: all pending state clears on that edge, and the counter restarts from 0 on the first cycle after `RESET_N` returns to 1.

## Test plan

- **RAM mask write:** write 0xDEADBEEF to 0x10 with `WR`=0xFFFF_FFFF, then write 0x0000_1234 with `WR`=0x0000_FFFF → reading 0x10 returns 0xDEAD1234; reading 0x12 returns the same (low bits ignored).
- **Same-cycle read/write:** address 0x20 holds 5; write 7 with the read address also at 0x20 → `D_IN`=5 that cycle and 7 the next. A write to `DEPTH_WORDS*4` leaves RAM unchanged; a read there returns 0.
- **Counter:** release reset → `CYCLE` reads 0, 1, 2 on consecutive cycles. Force the counter near wrap: 0xFFFF_FFFF is followed by 0.
- **Timer:** write `TCMP`=20 and `TSTAT`=0x2 → `IRQ` rises on the cycle after `CYCLE`=20. Writing `TSTAT`=0x3 clears it. If the clear lands on the same edge as a match, `IRQ` stays 1.
- **Peripherals and reset:** set `SW`=0xA5A5 → `SWREG` reads 0xA5A5 after exactly 2 cycles. Write `LED_REG`=0xF0, then assert `RESET_N`=0 for 1 cycle → `LED`=0, `IRQ`=0, `CYCLE`=0, and earlier RAM data is preserved.
